// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider for unsigned N-bit operands. One quotient
// bit is produced per cycle. A start is accepted only in IDLE. The accepting
// edge is counted as edge 0, and done is high after edge N+1.
//
// state | meaning
// IDLE  | waiting for start; operands are captured when start is accepted
// RUN   | one restoring step per cycle while cnt != 0; cnt == 0 is the
//       | finishing pass that loads the result registers
// DONE  | done pulse for one cycle, then back to IDLE
module shift_sub_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [N:0]    rem;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          dbz_pend;
  logic [N:0]    rem_sh;
  logic [N:0]    trial;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Trial subtraction. The partial remainder is always below the divisor,
  // so bit N of the difference is a reliable sign bit.
  always_comb begin
    rem_sh = (rem << 1) | {{N{1'b0}}, dvd[N-1]};
    trial  = rem_sh - {1'b0, dvs};
  end

  // Datapath and result registers. A zero divisor loads cnt with 0, so no
  // shift-subtract steps run. The finishing pass then reports the
  // divide-by-zero result, and done rises after edge 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      dbz_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= dividend;
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= (divisor == '0) ? '0 : CW'(N);
            dbz_pend <= (divisor == '0);
          end
        end
        RUN: begin
          if (cnt != '0) begin
            if (!trial[N]) begin
              rem <= trial;
              dvd <= {dvd[N-2:0], 1'b1};
            end else begin
              rem <= rem_sh;
              dvd <= {dvd[N-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
          end else if (dbz_pend) begin
            quotient  <= '1;
            remainder <= dvd;
            dbz       <= 1'b1;
          end else begin
            quotient  <= dvd;
            remainder <= rem[N-1:0];
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and random bench for shift_sub_divider. It drives an N=8 and an
// N=16 instance. Edge 0 is the edge that accepts start.
module tb_shift_sub_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dbz8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] q16, r16;
  logic        busy16, done16, dbz16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sub_divider #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .dbz(dbz8)
  );

  shift_sub_divider #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .dividend(a16), .divisor(b16),
    .quotient(q16), .remainder(r16), .busy(busy16), .done(done16), .dbz(dbz16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation: start is high for the accepting edge, then 20 edges
  // are watched for done and busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int done_edge, output int busy_n, output int done_n);
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    done_edge = -1;
    busy_n = busy8 ? 1 : 0;
    done_n = done8 ? 1 : 0;
    if (done8) done_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_edge < 0) done_edge = e;
      end
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      output int done_edge, output int done_n);
    a16 = a; b16 = b; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    done_edge = -1;
    done_n = done16 ? 1 : 0;
    if (done16) done_edge = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (done16) begin
        done_n++;
        if (done_edge < 0) done_edge = e;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
    tick();
    tick();
    total++;
    if ({q8, r8, busy8, done8, dbz8} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               q8, r8, busy8, done8, dbz8);
    end
    reset = 1'b0; start8 = 1'b0;
    tick();
    total++;
    if (busy8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_over_start: busy=%b want 0", busy8);
    end
  endtask

  task automatic test_basic();
    int de, bn, dn;
    op8(8'd100, 8'd7, de, bn, dn);
    total++;
    if (de !== 9) begin bad++; $display("FAIL basic_latency: done edge %0d want 9", de); end
    total++;
    if (bn !== 10) begin bad++; $display("FAIL basic_busy: busy cycles %0d want 10", bn); end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL basic_done_count: %0d want 1", dn); end
    total++;
    if ({q8, r8, dbz8} !== {8'd14, 8'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b want 14 2 0", q8, r8, dbz8);
    end
    a8 = 8'd1; b8 = 8'd1;
    repeat (3) tick();
    total++;
    if ({q8, r8} !== {8'd14, 8'd2}) begin
      bad++;
      $display("FAIL basic_hold: q=%0d r=%0d want 14 2", q8, r8);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'd255, 8'd3, 8'd7, 8'd0};
    logic [7:0] vb [4] = '{8'd1, 8'd10, 8'd7, 8'd5};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd1, 8'd0};
    logic [7:0] vr [4] = '{8'd0, 8'd3, 8'd0, 8'd0};
    int de, bn, dn;
    for (int i = 0; i < 4; i++) begin
      op8(va[i], vb[i], de, bn, dn);
      total++;
      if ({q8, r8, dbz8} !== {vq[i], vr[i], 1'b0}) begin
        bad++;
        $display("FAIL vector_%0d: %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                 i, va[i], vb[i], q8, r8, dbz8, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_dbz();
    int de, bn, dn;
    op8(8'd5, 8'd0, de, bn, dn);
    total++;
    if (de !== 1) begin bad++; $display("FAIL dbz_latency: done edge %0d want 1", de); end
    total++;
    if (bn !== 2) begin bad++; $display("FAIL dbz_busy: busy cycles %0d want 2", bn); end
    total++;
    if ({q8, r8, dbz8} !== {8'hFF, 8'd5, 1'b1}) begin
      bad++;
      $display("FAIL dbz_result: q=%0h r=%0d dbz=%b want ff 5 1", q8, r8, dbz8);
    end
    op8(8'd10, 8'd3, de, bn, dn);
    total++;
    if ({q8, r8, dbz8} !== {8'd3, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b want 3 1 0", q8, r8, dbz8);
    end
  endtask

  task automatic test_busy_start();
    int de = -1;
    int dn = 0;
    a8 = 8'd200; b8 = 8'd9; start8 = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      start8 = 1'b0;
      if (e == 3) begin
        start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
      end
      if (e == 5) begin a8 = 8'd0; b8 = 8'd0; end
      if (done8) begin
        dn++;
        if (de < 0) de = e;
      end
    end
    total++;
    if (dn !== 1 || de !== 9) begin
      bad++;
      $display("FAIL busy_start_done: count=%0d edge=%0d want 1 at 9", dn, de);
    end
    total++;
    if ({q8, r8} !== {8'd22, 8'd2}) begin
      bad++;
      $display("FAIL busy_start_result: q=%0d r=%0d want 22 2", q8, r8);
    end
  endtask

  task automatic test_reset_mid();
    int de, bn, dn;
    int stray = 0;
    a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({q8, r8, busy8, done8, dbz8} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
               q8, r8, busy8, done8, dbz8);
    end
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done8) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL reset_mid_no_done: saw %0d done want 0", stray); end
    op8(8'd81, 8'd9, de, bn, dn);
    total++;
    if ({q8, r8, de} !== {8'd9, 8'd0, 32'd9}) begin
      bad++;
      $display("FAIL reset_mid_next: q=%0d r=%0d edge=%0d want 9 0 at 9", q8, r8, de);
    end
  endtask

  task automatic test_held_start();
    int first = -1;
    int second = -1;
    int dn = 0;
    logic prev = 1'b0;
    int dbl = 0;
    a8 = 8'd20; b8 = 8'd4; start8 = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      if (e == 11) start8 = 1'b0;
      if (done8 && prev) dbl++;
      prev = done8;
      if (done8) begin
        dn++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
    end
    total++;
    if (dn !== 2 || first !== 9 || second !== 20) begin
      bad++;
      $display("FAIL held_start: count=%0d edges=%0d,%0d want 2 at 9,20", dn, first, second);
    end
    total++;
    if (dbl !== 0) begin bad++; $display("FAIL done_consecutive: %0d want 0", dbl); end
    total++;
    if ({q8, r8} !== {8'd5, 8'd0}) begin
      bad++;
      $display("FAIL held_start_result: q=%0d r=%0d want 5 0", q8, r8);
    end
  endtask

  task automatic test_random();
    int de, bn, dn;
    int unsigned a, b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(255, 0);
      b = $urandom_range(255, 1);
      op8(a[7:0], b[7:0], de, bn, dn);
      total++;
      if (int'(q8) * b + int'(r8) != a || int'(r8) >= b || de != 9 || dbz8 !== 1'b0) begin
        bad++;
        $display("FAIL rand8: %0d/%0d got q=%0d r=%0d edge=%0d want q=%0d r=%0d edge 9",
                 a, b, q8, r8, de, a / b, a % b);
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(65535, 0);
      b = (i < 4) ? $urandom_range(255, 1) : $urandom_range(65535, 1);
      op16(a[15:0], b[15:0], de, dn);
      total++;
      if (int'(q16) * b + int'(r16) != a || int'(r16) >= b || de != 17 || dn != 1) begin
        bad++;
        $display("FAIL rand16: %0d/%0d got q=%0d r=%0d edge=%0d want q=%0d r=%0d edge 17",
                 a, b, q16, r16, de, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_dbz();
    test_busy_start();
    test_reset_mid();
    test_held_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
